// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR / trap controller.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;

  localparam logic [31:0] MISA_VAL = 32'h4000_0100;

  localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;
  localparam logic [4:0] CAUSE_ECALL   = 5'd11;
  localparam logic [4:0] CODE_MSI      = 5'd3;
  localparam logic [4:0] CODE_MTI      = 5'd7;
  localparam logic [4:0] CODE_MEI      = 5'd11;

  // Fixed interrupts, highest priority first; platform lines 16+i follow,
  // lower index winning.
  localparam logic [4:0] IRQ_PRIO_FIXED [3] = '{CODE_MEI, CODE_MSI, CODE_MTI};

  typedef enum logic {IDLE, REQ} trap_state_t;

  typedef enum logic [1:0] {OP_NONE = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11} csr_op_t;

endpackage

// File: rtl/csr_trap_unit_counter.sv
// Free-running counter with split 32-bit write ports; a write replaces the increment.
module csr_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             inhibit,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  output logic [CNT_W-1:0] value
);

  // Writes to either half win over counting; the untouched half keeps its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (wr_lo) begin
      value[31:0] <= wdata;
    end else if (wr_hi) begin
      value[CNT_W-1:32] <= wdata[CNT_W-33:0];
    end else if (inc && !inhibit) begin
      value <= value + CNT_W'(1);
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller with req/ack trap delivery.
//
//   state | meaning
//   IDLE  | no trap outstanding; causes and mret are evaluated
//   REQ   | trap_req high, trap_vec frozen, waiting for trap_ack
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int                 NUM_IRQ  = 4,
  parameter logic [NUM_IRQ-1:0] IRQ_EDGE = '0,
  parameter int                 CNT_W    = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               csr_cmd_ex,
  input  logic [11:0]        csr_ofs_ex,
  input  logic [2:0]         csr_op2_ex,
  input  logic [4:0]         csr_uimm_ex,
  input  logic [31:0]        rs1_sel,
  output logic [31:0]        csr_rd_data,
  output logic               csr_illegal,
  input  logic               retire,
  input  logic               ecall_ex,
  input  logic               illegal_ops_ex,
  input  logic               mret_ex,
  input  logic [31:0]        tval_ex,
  input  logic [31:2]        pc_excep,
  input  logic [NUM_IRQ-1:0] irq_ext,
  input  logic               irq_timer,
  input  logic               irq_soft,
  output logic               trap_req,
  output logic [31:2]        trap_vec,
  input  logic               trap_ack,
  output logic               mret_req,
  output logic [31:2]        mepc_out
);

  localparam logic [31:0] MIE_MASK = 32'h0000_0888 | (((32'd1 << NUM_IRQ) - 32'd1) << 16);

  trap_state_t state, state_nxt;
  logic               mie_bit, mpie_bit, mtvec_vec, inh_cy, inh_ir;
  logic [31:0]        mie_reg, mscratch, mcause, mtval, mip_val, pend;
  logic [31:2]        mtvec_base, mepc, vec_nxt;
  logic [NUM_IRQ-1:0] irq_q, edge_lat;
  logic [CNT_W-1:0]   cyc, ins;
  logic [63:0]        cyc64, ins64;
  logic [31:0]        src, wdata;
  logic               known, is_wr, csr_we;
  logic               exc_take, irq_take, trap_take, mret_take, idle;
  logic [4:0]         irq_code, cause_code;

  assign cyc64 = 64'(cyc);
  assign ins64 = 64'(ins);
  assign idle  = (state == IDLE);
  assign is_wr = (csr_op2_ex[1:0] != OP_NONE);
  assign src   = csr_op2_ex[2] ? {27'd0, csr_uimm_ex} : rs1_sel;

  // Pending interrupt view: fixed lines plus level or edge-latched platform lines.
  always_comb begin
    mip_val = '0;
    for (int i = 0; i < NUM_IRQ; i++) mip_val[16+i] = IRQ_EDGE[i] ? edge_lat[i] : irq_ext[i];
    mip_val[11] = |irq_ext;
    mip_val[7]  = irq_timer;
    mip_val[3]  = irq_soft;
  end

  // Combinational CSR read decode; unknown addresses read zero.
  always_comb begin
    csr_rd_data = '0;
    known       = 1'b1;
    case (csr_ofs_ex)
      CSR_MSTATUS:       csr_rd_data = {19'd0, 2'b11, 3'd0, mpie_bit, 3'd0, mie_bit, 3'd0};
      CSR_MISA:          csr_rd_data = MISA_VAL;
      CSR_MIE:           csr_rd_data = mie_reg;
      CSR_MTVEC:         csr_rd_data = {mtvec_base, 1'b0, mtvec_vec};
      CSR_MCOUNTINHIBIT: csr_rd_data = {29'd0, inh_ir, 1'b0, inh_cy};
      CSR_MSCRATCH:      csr_rd_data = mscratch;
      CSR_MEPC:          csr_rd_data = {mepc, 2'b00};
      CSR_MCAUSE:        csr_rd_data = mcause;
      CSR_MTVAL:         csr_rd_data = mtval;
      CSR_MIP:           csr_rd_data = mip_val;
      CSR_MCYCLE:        csr_rd_data = cyc64[31:0];
      CSR_MINSTRET:      csr_rd_data = ins64[31:0];
      CSR_MCYCLEH:       csr_rd_data = cyc64[63:32];
      CSR_MINSTRETH:     csr_rd_data = ins64[63:32];
      default:           known = 1'b0;
    endcase
  end

  assign csr_illegal = csr_cmd_ex & (~known | ((csr_ofs_ex == CSR_MISA) & is_wr));

  // Read-modify-write data from the current CSR value.
  always_comb begin
    case (csr_op2_ex[1:0])
      OP_RW:   wdata = src;
      OP_RS:   wdata = src | csr_rd_data;
      OP_RC:   wdata = ~src & csr_rd_data;
      default: wdata = csr_rd_data;
    endcase
  end

  // Highest-priority enabled interrupt; platform lines first so fixed lines override.
  always_comb begin
    pend     = mip_val & mie_reg;
    irq_code = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (pend[16+i]) irq_code = 5'(16 + i);
    for (int k = 2; k >= 0; k--) if (pend[IRQ_PRIO_FIXED[k]]) irq_code = IRQ_PRIO_FIXED[k];
  end

  assign exc_take   = idle & (illegal_ops_ex | ecall_ex);
  assign irq_take   = idle & ~exc_take & mie_bit & (|pend);
  assign trap_take  = exc_take | irq_take;
  assign mret_take  = idle & mret_ex & ~trap_take;
  assign cause_code = exc_take ? (illegal_ops_ex ? CAUSE_ILLEGAL : CAUSE_ECALL) : irq_code;
  assign vec_nxt    = (irq_take && mtvec_vec) ? mtvec_base + 30'(irq_code) : mtvec_base;
  assign csr_we     = csr_cmd_ex & ~stall & ~csr_illegal & is_wr & ~exc_take;

  // Trap FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Trap FSM next state and request output.
  always_comb begin
    state_nxt = state;
    trap_req  = 1'b0;
    case (state)
      IDLE: if (trap_take) state_nxt = REQ;
      REQ: begin
        trap_req = 1'b1;
        if (trap_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // CSR register file; later assignments (mret, trap capture) override CSR writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      mie_bit    <= 1'b0;
      mpie_bit   <= 1'b0;
      mie_reg    <= '0;
      mtvec_base <= '0;
      mtvec_vec  <= 1'b0;
      inh_cy     <= 1'b0;
      inh_ir     <= 1'b0;
      mscratch   <= '0;
      mepc       <= '0;
      mcause     <= '0;
      mtval      <= '0;
      trap_vec   <= '0;
    end else begin
      if (csr_we) begin
        case (csr_ofs_ex)
          CSR_MSTATUS: begin
            mie_bit  <= wdata[3];
            mpie_bit <= wdata[7];
          end
          CSR_MIE: mie_reg <= wdata & MIE_MASK;
          CSR_MTVEC: begin
            mtvec_base <= wdata[31:2];
            mtvec_vec  <= (wdata[1:0] == 2'b01);
          end
          CSR_MCOUNTINHIBIT: begin
            inh_cy <= wdata[0];
            inh_ir <= wdata[2];
          end
          CSR_MSCRATCH: mscratch <= wdata;
          CSR_MEPC:     mepc <= wdata[31:2];
          CSR_MCAUSE:   mcause <= wdata;
          CSR_MTVAL:    mtval <= wdata;
          default: ;
        endcase
      end
      if (mret_take) begin
        mie_bit  <= mpie_bit;
        mpie_bit <= 1'b1;
      end
      if (trap_take) begin
        mpie_bit <= mie_bit;
        mie_bit  <= 1'b0;
        mepc     <= pc_excep;
        mcause   <= {irq_take, 26'd0, cause_code};
        mtval    <= exc_take ? tval_ex : 32'd0;
        trap_vec <= vec_nxt;
      end
    end
  end

  // Edge latches for platform lines; a rising edge wins over a clearing write.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q    <= '0;
      edge_lat <= '0;
    end else begin
      irq_q <= irq_ext;
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (irq_ext[i] && !irq_q[i])                                  edge_lat[i] <= 1'b1;
        else if (csr_we && csr_ofs_ex == CSR_MIP && !wdata[16+i])     edge_lat[i] <= 1'b0;
      end
    end
  end

  // One-cycle mret pulse carrying the saved return address.
  always_ff @(posedge clk) begin
    if (rst) begin
      mret_req <= 1'b0;
      mepc_out <= '0;
    end else begin
      mret_req <= mret_take;
      if (mret_take) mepc_out <= mepc;
    end
  end

  csr_counter #(.CNT_W(CNT_W)) u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .inc     (1'b1),
    .inhibit (inh_cy),
    .wr_lo   (csr_we && csr_ofs_ex == CSR_MCYCLE),
    .wr_hi   (csr_we && csr_ofs_ex == CSR_MCYCLEH),
    .wdata   (wdata),
    .value   (cyc)
  );

  csr_counter #(.CNT_W(CNT_W)) u_minstret (
    .clk     (clk),
    .rst     (rst),
    .inc     (retire & ~stall),
    .inhibit (inh_ir),
    .wr_lo   (csr_we && csr_ofs_ex == CSR_MINSTRET),
    .wr_hi   (csr_we && csr_ofs_ex == CSR_MINSTRETH),
    .wdata   (wdata),
    .value   (ins)
  );

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: random CSR traffic against a value model,
// then directed trap, priority, edge-latch, counter and reset scenarios.
module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst, stall, csr_cmd_ex, csr_illegal, retire;
  logic [11:0] csr_ofs_ex;
  logic [2:0]  csr_op2_ex;
  logic [4:0]  csr_uimm_ex;
  logic [31:0] rs1_sel, csr_rd_data, tval_ex;
  logic        ecall_ex, illegal_ops_ex, mret_ex, irq_timer, irq_soft;
  logic [31:2] pc_excep, trap_vec, mepc_out;
  logic [3:0]  irq_ext;
  logic        trap_req, trap_ack, mret_req;

  int n_total = 0;
  int n_bad   = 0;

  logic [11:0] addr_tab [7] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343};
  logic [31:0] mdl [7];

  always #50 clk = ~clk;

  csr_trap_unit #(.NUM_IRQ(4), .IRQ_EDGE(4'b0010), .CNT_W(40)) dut (
    .clk(clk), .rst(rst), .stall(stall), .csr_cmd_ex(csr_cmd_ex), .csr_ofs_ex(csr_ofs_ex),
    .csr_op2_ex(csr_op2_ex), .csr_uimm_ex(csr_uimm_ex), .rs1_sel(rs1_sel),
    .csr_rd_data(csr_rd_data), .csr_illegal(csr_illegal), .retire(retire),
    .ecall_ex(ecall_ex), .illegal_ops_ex(illegal_ops_ex), .mret_ex(mret_ex),
    .tval_ex(tval_ex), .pc_excep(pc_excep), .irq_ext(irq_ext), .irq_timer(irq_timer),
    .irq_soft(irq_soft), .trap_req(trap_req), .trap_vec(trap_vec), .trap_ack(trap_ack),
    .mret_req(mret_req), .mepc_out(mepc_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    csr_cmd_ex = 1'b0;
    csr_ofs_ex = a;
    #1;
    v = csr_rd_data;
  endtask

  task automatic csr_op(input logic [11:0] a, input logic [2:0] f3, input logic [31:0] r,
                        input logic [4:0] z, output logic [31:0] old, output logic ill);
    csr_cmd_ex  = 1'b1;
    csr_ofs_ex  = a;
    csr_op2_ex  = f3;
    rs1_sel     = r;
    csr_uimm_ex = z;
    #1;
    old = csr_rd_data;
    ill = csr_illegal;
    tick();
    csr_cmd_ex = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] v);
    logic [31:0] o;
    logic        i;
    csr_op(a, 3'b001, v, 5'd0, o, i);
  endtask

  // What each modelled CSR keeps of a written value.
  function automatic logic [31:0] legalize(input int idx, input logic [31:0] w);
    case (idx)
      0:       return (w & 32'h88) | 32'h1800;
      1:       return w & 32'h000F_0888;
      2:       return {w[31:2], 1'b0, w[1:0] == 2'b01};
      4:       return w & 32'hFFFF_FFFC;
      default: return w;
    endcase
  endfunction

  initial begin
    #(100 * 5000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, o, a, b, r0, c0;
    logic        ill;
    rst = 1; stall = 0; csr_cmd_ex = 0; csr_ofs_ex = 0; csr_op2_ex = 0; csr_uimm_ex = 0;
    rs1_sel = 0; retire = 0; ecall_ex = 0; illegal_ops_ex = 0; mret_ex = 0; tval_ex = 0;
    pc_excep = 0; irq_ext = 0; irq_timer = 0; irq_soft = 0; trap_ack = 0;
    tick(); tick();
    check("rst_trap_req", trap_req, 0);
    check("rst_mret_req", mret_req, 0);
    check("rst_trap_vec", trap_vec, 0);
    check("rst_mepc_out", mepc_out, 0);
    rst = 0;
    rd(12'h300, v); check("rst_mstatus", v, 32'h1800);
    rd(12'h301, v); check("rst_misa", v, 32'h4000_0100);
    rd(12'h305, v); check("rst_mtvec", v, 0);
    rd(12'h342, v); check("rst_mcause", v, 0);
    rd(12'h344, v); check("rst_mip", v, 0);

    mdl[0] = 32'h1800;
    for (int k = 1; k < 7; k++) mdl[k] = 0;
    for (int it = 0; it < 48; it++) begin
      int          idx;
      logic [1:0]  op;
      logic        imm, st;
      logic [31:0] r, src, nv, got_old;
      logic [4:0]  z;
      idx = $urandom_range(0, 6);
      op  = 2'($urandom_range(1, 3));
      imm = 1'($urandom_range(0, 1));
      st  = ($urandom_range(0, 3) == 0);
      r   = $urandom;
      z   = 5'($urandom_range(0, 31));
      src = imm ? {27'd0, z} : r;
      case (op)
        2'd1:    nv = src;
        2'd2:    nv = src | mdl[idx];
        default: nv = ~src & mdl[idx];
      endcase
      stall = st;
      csr_op(addr_tab[idx], {imm, op}, r, z, got_old, ill);
      stall = 0;
      check("rnd_old", got_old, mdl[idx]);
      if (!st) mdl[idx] = legalize(idx, nv);
      rd(addr_tab[idx], v);
      check("rnd_rd", v, mdl[idx]);
    end

    csr_op(12'h340, 3'b001, 32'hA5A5_0000, 5'd0, o, ill);
    check("scratch_legal", ill, 0);
    csr_op(12'h340, 3'b110, 32'd0, 5'd3, o, ill);
    csr_op(12'h340, 3'b011, 32'hA000_0000, 5'd0, o, ill);
    rd(12'h340, v); check("scratch_val", v, 32'h05A5_0003);

    csr_op(12'h7C0, 3'b001, 32'h1234, 5'd0, o, ill);
    check("unmapped_ill", ill, 1);
    rd(12'h7C0, v); check("unmapped_rd", v, 0);
    csr_op(12'h301, 3'b001, 32'd0, 5'd0, o, ill);
    check("misa_ill", ill, 1);
    rd(12'h301, v); check("misa_kept", v, 32'h4000_0100);

    wr(12'h300, 0); wr(12'h304, 32'h80); wr(12'h305, 32'h101);
    pc_excep = 30'(32'h200 >> 2);
    irq_timer = 1;
    wr(12'h300, 32'h8);
    check("tmr_not_yet", trap_req, 0);
    tick();
    check("tmr_req1", trap_req, 1);
    check("tmr_vec", trap_vec, 30'h47);
    rd(12'h341, v); check("tmr_mepc", v, 32'h200);
    rd(12'h342, v); check("tmr_mcause", v, 32'h8000_0007);
    rd(12'h343, v); check("tmr_mtval", v, 0);
    rd(12'h300, v); check("tmr_mstatus", v, 32'h1880);
    irq_timer = 0;
    tick(); check("tmr_req2", trap_req, 1); check("tmr_vec_hold", trap_vec, 30'h47);
    tick(); check("tmr_req3", trap_req, 1);
    trap_ack = 1; tick(); trap_ack = 0;
    check("tmr_req_done", trap_req, 0);

    wr(12'h304, 32'h000F_0888); wr(12'h305, 32'h100);
    irq_soft = 1;
    pc_excep = 30'(32'h300 >> 2);
    irq_ext = 4'b0010; tick(); irq_ext = 0;
    rd(12'h344, v); check("pri_mip", v, 32'h0002_0008);
    csr_op(12'h300, 3'b010, 32'h8, 5'd0, o, ill);
    check("pri_not_yet", trap_req, 0);
    tick();
    check("pri_req_a", trap_req, 1);
    rd(12'h342, v); check("pri_cause_a", v, 32'h8000_0003);
    check("pri_vec_a", trap_vec, 30'h40);
    irq_soft = 0;
    trap_ack = 1; tick(); trap_ack = 0;
    mret_ex = 1; tick(); mret_ex = 0;
    check("mret_pulse", mret_req, 1);
    check("mret_pc", mepc_out, 30'hC0);
    tick();
    check("pri_req_b", trap_req, 1);
    check("mret_one_cycle", mret_req, 0);
    rd(12'h342, v); check("pri_cause_b", v, 32'h8000_0011);
    trap_ack = 1; tick(); trap_ack = 0;
    csr_op(12'h344, 3'b011, 32'h0002_0000, 5'd0, o, ill);
    rd(12'h344, v); check("latch_clear", v, 0);
    mret_ex = 1; tick(); mret_ex = 0;
    tick(); tick(); tick();
    check("no_reentry", trap_req, 0);
    rd(12'h300, v); check("mie_restored", v, 32'h1888);

    pc_excep = 30'(32'h400 >> 2);
    irq_timer = 1; illegal_ops_ex = 1; tval_ex = 32'h1234;
    csr_op(12'h305, 3'b001, 32'h5550, 5'd0, o, ill);
    illegal_ops_ex = 0; irq_timer = 0;
    check("sim_req", trap_req, 1);
    rd(12'h342, v); check("sim_mcause", v, 32'h2);
    rd(12'h343, v); check("sim_mtval", v, 32'h1234);
    rd(12'h305, v); check("sim_mtvec", v, 32'h100);
    rd(12'h341, v); check("sim_mepc", v, 32'h400);
    trap_ack = 1; tick(); trap_ack = 0;

    wr(12'h320, 32'hFFFF_FFFF);
    rd(12'h320, v); check("inh_mask", v, 32'h5);
    wr(12'h320, 0);
    wr(12'hB80, 32'hFFFF_FFFF); wr(12'hB00, 32'hFFFF_FFFF);
    rd(12'hB00, v); check("cyc_lo_max", v, 32'hFFFF_FFFF);
    rd(12'hB80, v); check("cyc_hi_max", v, 32'hFF);
    tick();
    rd(12'hB00, v); check("cyc_wrap_lo", v, 0);
    rd(12'hB80, v); check("cyc_wrap_hi", v, 0);
    rd(12'hB00, a);
    repeat (7) tick();
    rd(12'hB00, b); check("cyc_count", b, a + 7);
    wr(12'h320, 1);
    rd(12'hB00, a);
    repeat (5) tick();
    rd(12'hB00, b); check("cyc_frozen", b, a);
    wr(12'h320, 0);
    retire = 1;
    rd(12'hB02, r0); rd(12'hB00, c0);
    csr_op(12'hB80, 3'b001, 32'h12, 5'd0, o, ill);
    rd(12'hB02, v); check("ins_with_hwrite", v, r0 + 1);
    rd(12'hB00, v); check("cyc_lo_no_carry", v, c0);
    rd(12'hB80, v); check("cyc_hi_written", v, 32'h12);
    repeat (3) tick();
    rd(12'hB02, v); check("ins_count", v, r0 + 4);
    stall = 1; repeat (2) tick(); stall = 0;
    rd(12'hB02, v); check("ins_stall", v, r0 + 4);
    wr(12'h320, 4);
    repeat (2) tick();
    rd(12'hB02, v); check("ins_inhibit", v, r0 + 5);
    wr(12'h320, 0);
    retire = 0;

    ecall_ex = 1; tval_ex = 32'hDEAD; tick(); ecall_ex = 0;
    check("ecall_req", trap_req, 1);
    rd(12'h342, v); check("ecall_cause", v, 32'hB);
    rd(12'h343, v); check("ecall_tval", v, 32'hDEAD);
    irq_ext = 4'b0010; tick(); irq_ext = 0;
    rd(12'h344, v); check("req_latch_pend", v, 32'h0002_0000);
    rst = 1; tick(); rst = 0;
    check("rst_mid_req", trap_req, 0);
    check("rst_vec", trap_vec, 0);
    rd(12'h344, v); check("rst_latch", v, 0);
    rd(12'h300, v); check("rst_mstatus2", v, 32'h1800);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/csr_trap_unit.md
# csr_trap_unit

Parametrised machine-mode CSR and trap controller for the RV32I core; successor to the single-interrupt CSR array. Sits beside EX: services CSR instructions, owns mstatus/mie/mip/mtvec/mepc/mcause/mtval/mscratch plus mcycle/minstret counters, and arbitrates among NUM_IRQ platform interrupts, timer, software interrupts and synchronous exceptions. Traps are delivered to the fetch stage through a req/ack handshake.

## Interface
- NUM_IRQ, 4: platform interrupt lines, mapped to mip/mie bits 16+i (1..16).
- IRQ_EDGE, 0: NUM_IRQ-bit mask; 1 = edge-latched line, 0 = level line.
- CNT_W, 64: mcycle/minstret width (33..64); bits at or above CNT_W read 0.
- clk  in  1  core clock.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  pipeline stall; blocks CSR writes and retire counting.
- csr_cmd_ex  in  1  CSR instruction in EX.
- csr_ofs_ex  in  12  CSR address.
- csr_op2_ex  in  3  funct3 ([2] = immediate, [1:0] 01 RW / 10 RS / 11 RC).
- csr_uimm_ex  in  5  zimm; rs1_sel  in  32  rs1 value.
- csr_rd_data  out  32  read data, combinational.
- csr_illegal  out  1  unmapped address, or write to a read-only CSR, while csr_cmd_ex.
- retire  in  1  instruction retired this cycle.
- ecall_ex, illegal_ops_ex, mret_ex  in  1 each.
- tval_ex  in  32  faulting value; pc_excep  in  [31:2]  PC of the EX instruction.
- irq_ext  in  NUM_IRQ; irq_timer, irq_soft  in  1 each.
- trap_req  out  1; trap_vec  out  [31:2]; trap_ack  in  1.
- mret_req  out  1  one-cycle pulse; mepc_out  out  [31:2].

## Operation
- CSR map: mstatus 300, misa 301 (RO 0x4000_0100), mie 304, mtvec 305, mcountinhibit 320 (bits 0 and 2 only), mscratch 340, mepc 341, mcause 342, mtval 343, mip 344, mcycle B00, minstret B02, mcycleh B80, minstreth B82.
- Any other address reads 0 and raises csr_illegal. A write to misa raises csr_illegal and is discarded.
- Write data: RW = src, RS = src | old, RC = ~src & old. src = zimm zero-extended when [2] is set, otherwise rs1_sel.
- Writes are applied when csr_cmd_ex & ~stall & ~csr_illegal.
- mstatus implements MIE[3], MPIE[7], MPP[12:11] only. MPP is WARL and always reads 11.
- mip bits:
  - MEIP[11] = OR of all irq_ext lines.
  - MTIP[7] = irq_timer; MSIP[3] = irq_soft.
  - Bit 16+i is a level line or an edge latch, per IRQ_EDGE.
  - An edge latch sets on the rising edge of irq_ext[i] and clears on a csrrc/csrrw write of 0 to that bit. Set wins over clear in the same cycle.
  - All other mip bits are read-only.
- Trap cause selection, evaluated in IDLE only:
  - Synchronous exceptions win: illegal_ops_ex (cause 2), then ecall_ex (cause 11).
  - Otherwise an interrupt is taken when mstatus.MIE & |(mip & mie).
  - Interrupt priority: 11 > 3 > 7 > 16 > 17 > ...; mcause[31] = 1.
- Trap capture, single edge:
  - mepc = pc_excep.
  - mcause = {int, code}.
  - mtval = tval_ex for exceptions, 0 for interrupts.
  - MPIE = MIE, MIE = 0.
- trap_vec = mtvec[31:2]. When mtvec[1:0] == 01 and the trap is an interrupt, trap_vec = mtvec[31:2] + code. mtvec mode 1x reads back as 00.
- FSM:
  - IDLE -> REQ on capture. trap_req = 1 in REQ.
  - REQ -> IDLE on trap_ack; trap_vec is held stable throughout REQ.
  - New causes stay pending in REQ.
- mret_ex in IDLE:
  - MIE = MPIE, MPIE = 1.
  - mret_req pulses for one cycle with mepc_out = mepc.
  - mret_ex in REQ is ignored.
- Counters:
  - mcycle increments every cycle unless mcountinhibit[0] is set.
  - minstret increments on retire & ~stall unless mcountinhibit[2] is set.
  - Both wrap modulo 2^CNT_W.
  - A CSR write to either half replaces the increment in that cycle. The other half keeps its old value with no carry.

## Timing
- Reset values:
  - mstatus 0x0000_1800; all other registers 0.
  - trap_req 0, mret_req 0, trap_vec 0, mepc_out 0, edge latches 0.
- Read data is combinational in the same cycle; writes take effect at the next edge.
- trap_req rises one cycle after the cause is seen. Minimum REQ duration is 1 cycle when trap_ack is already high.
- Exception together with a CSR write in the same cycle: the write is dropped.
- Interrupt together with a CSR write: the write is applied, except that trap updates win on mepc, mcause, mtval and MIE/MPIE.
- Exception together with mret_ex: the exception wins.
- rst asserted mid-REQ returns the FSM to IDLE on the next edge and drops all pending edge latches.

## Structure
- Package csr_pkg holds:
  - CSR address constants, MISA value and cause codes.
  - The trap FSM state enum {IDLE, REQ}.
  - The interrupt priority order.
- Sub-module csr_counter (parameter CNT_W): increment enable, inhibit, and lo/hi write ports with write-over-increment priority. It is instantiated twice, for mcycle and minstret.

## Test plan
- CSR ops: csrrw mscratch 0xA5A5_0000, then csrrsi 0x3, then csrrc 0xA000_0000 -> reads 0x05A5_0003.
- Unmapped/read-only access: csrrw 0x7C0, then csrrw misa -> csr_illegal = 1 each time; misa still reads 0x4000_0100.
- Vectored timer interrupt: mtvec = 0x101, MIE = 1, mie[7] = 1, irq_timer = 1, pc_excep = 0x200>>2.
  - Required: mepc 0x200, mcause 0x8000_0007, trap_vec = (0x100>>2)+7.
  - trap_req is held for 3 cycles until ack; MIE reads 0.
- Priority and edge latch: NUM_IRQ = 4, IRQ_EDGE = 4'b0010, irq_ext[1] pulsed with irq_soft high, all mie enabled.
  - Required: cause 3 is taken first; after mret and ack, cause 17 is taken.
  - Clearing mip[17] stops re-entry.
- Simultaneous events: illegal_ops_ex with a pending enabled interrupt and a csrrw mtvec -> mcause 2, mtvec unchanged.
- Counter boundaries (CNT_W = 40):
  - mcycle written 0xFF_FFFF_FFFF wraps to 0 in 1 cycle.
  - mcountinhibit = 1 freezes mcycle.
  - Writing mcycleh at retire leaves minstret still counting.
